idu_alu_issue: RTL
==================

# idu_alu_issue

Decode-and-issue stage that feeds the execute-stage ALU. It accepts a fetched 32-bit RV32I instruction with its PC under a valid/ready handshake. It decodes ALU-class instructions into the 4-bit ALU control code, reads the register file, and selects operands. The result is held in a one-entry pipeline register that the EXU drains under its own valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous kill of held and incoming instruction
- `in_valid`  in  1  IFU has an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_inst`  in  32  instruction word
- `in_pc`  in  XLEN  PC of `in_inst`
- `rf_raddr1`, `rf_raddr2`  out  5 each  register-file read indices, combinational from `in_inst[19:15]`, `[24:20]`
- `rf_rdata1`, `rf_rdata2`  in  XLEN each  register-file read data, same cycle
- `out_valid`  out  1  held instruction valid
- `out_ready`  in  1  EXU accepts
- `out_alu_ctr`  out  4  ALU control code
- `out_alu_a`, `out_alu_b`  out  XLEN each  ALU operands
- `out_rd`  out  5  destination register
- `out_wb_en`  out  1  result writes `out_rd`
- `out_br`  out  3  branch condition: funct3 of BRANCH, 3'b010 = none
- `out_br_tgt`  out  XLEN  PC + B-immediate
- `out_illegal`  out  1  unsupported/illegal encoding

## Operation
- ALU code `{sa/al/us, op[2:0]}`:
  - 0000 add
  - 1000 sub
  - 0001 sll
  - 0010 slt
  - 1010 sltu
  - 0011 pass b
  - 0100 xor
  - 0101 srl
  - 1101 sra
  - 0110 or
  - 0111 and
- OP (0110011): code from funct3, with bit3 = funct7[5] for add/sub and srl/sra. Operands: a = rs1, b = rs2. Any funct7 other than 0x00/0x20, or 0x20 on funct3 other than 000/101, is illegal.
- OP-IMM (0010011): the same mapping, with b = sign-extended I-immediate. There is no subi: funct3 000 is always 0000. Shift immediates: b = {27'b0, shamt}. imm[11:5] must be 0x00 (or 0x20 for srai), otherwise the encoding is illegal.
- LUI: code 0011, b = {imm[31:12], 12'b0}, a = 0.
- AUIPC: code 0000, a = `in_pc`, b = U-immediate.
- BRANCH: `out_wb_en` = 0 and `out_br` = funct3. a = rs1, b = rs2.
  - beq/bne: code 1000
  - blt/bge: code 0010
  - bltu/bgeu: code 1010
  - funct3 010/011 is illegal.
- `out_wb_en` = 1 for OP, OP-IMM, LUI and AUIPC when rd ≠ 0. rd = 0 gives `out_wb_en` = 0.
- `out_br` = 3'b010 for every non-branch instruction.
- Any other opcode: `out_illegal` = 1, `out_wb_en` = 0, code 0000, operands 0.
- An illegal instruction still occupies the slot and is handed to the EXU.

## Timing
- Transfer happens on `valid & ready` at the rising edge, on both sides.
- `in_ready = ~out_valid | out_ready`. This is combinational, so a full-throughput pipe with no bubble is possible.
- Latency is 1 cycle. Instruction accepted at edge N appears on the outputs from N until it is consumed. Register data is sampled at the accept edge.
- Outputs are stable while `out_valid & ~out_ready`.
- `out_valid` holds until the EXU accepts. It never drops without a transfer, except on `flush`.
- On accept and drain in the same edge, the new instruction replaces the old one.
- `flush`: `out_valid` ← 0 at the edge. Any `in_valid` in that cycle is discarded. `in_ready` = 1 during flush.
- Reset (async, any time including mid-transfer) sets every register output to 0 and `out_br` to 3'b010, giving `out_valid` = 0 and `in_ready` = 1. Deassertion is synchronised outside this block.

## Structure
- Shared package holds:
  - opcode constants
  - ALU code constants (ALU_ADD … ALU_AND, 4 bits)
  - branch-none constant
  - XLEN
- One sub-module, `imm_gen`: combinational I/U/B immediate extraction with sign extension.
- Decode logic and the pipeline register live in the top module.

## Test plan
- `0x00500093` (addi x1,x0,5), `rf_rdata1`=0 → `out_alu_ctr`=0000, a=0, b=5, rd=1, `out_wb_en`=1, one cycle later.
- `0x402081B3` (sub x3,x1,x2), rs1=7, rs2=9 → code 1000, a=7, b=9. `0x40335293` (srai x5,x6,3) → code 1101, b=3.
- `0x123450B7` (lui x1) → code 0011, a=0, b=0x12345000. `0x0020B1B3` (sltu) → code 1010.
- Back-pressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, outputs unchanged. Release → the next instruction issues the following cycle with no loss or duplication.
- `0xFFFFFFFF` → `out_illegal`=1, `out_wb_en`=0. `flush` while full → `out_valid`=0 next edge and the incoming instruction is dropped.
- Assert `rst_n`=0 mid-stream asynchronously → all outputs reset immediately, with no clock edge required.

Source files
------------

// File: rtl/idu_alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module : idu_alu_issue_pkg
// Purpose: Shared constants and types for the ALU decode/issue stage:
//          RV32I opcodes, 4-bit ALU control codes, the branch-none code,
//          the issue-slot payload struct and the funct3-to-ALU mapping.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package idu_alu_issue_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b1010;
   localparam logic [3:0] ALU_PASB = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam logic [2:0] BR_NONE = 3'b010;

   typedef struct packed {
      logic [3:0]      alu_ctr;
      logic [XLEN-1:0] alu_a;
      logic [XLEN-1:0] alu_b;
      logic [4:0]      rd;
      logic            wb_en;
      logic [2:0]      br;
      logic [XLEN-1:0] br_tgt;
      logic            illegal;
   } issue_t;

   localparam issue_t ISSUE_RST = '{alu_ctr: 4'b0, alu_a: '0, alu_b: '0, rd: 5'b0,
                                    wb_en: 1'b0, br: BR_NONE, br_tgt: '0, illegal: 1'b0};

   // funct3 to ALU code; alt selects sub/sra. sltu is not {0,funct3}.
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      logic [3:0] code;
      code = ALU_ADD;
      case (f3)
         3'b000:  code = alt ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/idu_alu_issue_imm_gen.sv
`default_nettype none
// ============================================================================
// Module : idu_alu_issue_imm_gen
// Purpose: Combinational I/U/B immediate extraction with sign extension.
// Ports  : inst_i   - 32-bit instruction word
//          imm_i_o  - sign-extended I-immediate
//          imm_u_o  - U-immediate ({inst[31:12], 12'b0})
//          imm_b_o  - sign-extended B-immediate (byte offset)
// Rev    : 1.0  initial release
// ============================================================================
module idu_alu_issue_imm_gen (
   input  logic [31:0] inst_i,
   output logic [31:0] imm_i_o,
   output logic [31:0] imm_u_o,
   output logic [31:0] imm_b_o
);

   assign imm_i_o = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_u_o = {inst_i[31:12], 12'b0};
   assign imm_b_o = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

endmodule
`default_nettype wire

// File: rtl/idu_alu_issue.sv
`default_nettype none
// ============================================================================
// Module : idu_alu_issue
// Purpose: RV32I decode-and-issue stage for the ALU. Decodes ALU-class
//          instructions, reads the register file, selects operands and holds
//          the result in a one-entry slot drained by the EXU.
// Ports  : clk/rst_n           - clock, async active-low reset
//          flush               - kill held and incoming instruction
//          in_valid/in_ready   - IFU handshake, in_inst/in_pc payload
//          rf_raddr1/2, rf_rdata1/2 - same-cycle register file read
//          out_valid/out_ready - EXU handshake
//          out_alu_ctr/a/b, out_rd, out_wb_en, out_br, out_br_tgt,
//          out_illegal         - issued payload
// Rev    : 1.0  initial release
// ============================================================================
module idu_alu_issue #(
   parameter int XLEN = 32   // only 32 is supported
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic [4:0]      rf_raddr1,
   output logic [4:0]      rf_raddr2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_alu_ctr,
   output logic [XLEN-1:0] out_alu_a,
   output logic [XLEN-1:0] out_alu_b,
   output logic [4:0]      out_rd,
   output logic            out_wb_en,
   output logic [2:0]      out_br,
   output logic [XLEN-1:0] out_br_tgt,
   output logic            out_illegal
);
   import idu_alu_issue_pkg::*;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd;
   logic [31:0] imm_i, imm_u, imm_b;
   logic        accept;
   logic        valid_q, valid_d;
   issue_t      slot_q, slot_d;

   assign opc = in_inst[6:0];
   assign rd  = in_inst[11:7];
   assign f3  = in_inst[14:12];
   assign f7  = in_inst[31:25];

   assign rf_raddr1 = in_inst[19:15];
   assign rf_raddr2 = in_inst[24:20];

   idu_alu_issue_imm_gen u_imm_gen (
      .inst_i  (in_inst),
      .imm_i_o (imm_i),
      .imm_u_o (imm_u),
      .imm_b_o (imm_b)
   );

   // Decode; any illegal encoding falls back to code 0, operands 0, no write.
   always_comb begin
      slot_d         = ISSUE_RST;
      slot_d.rd      = rd;
      slot_d.br_tgt  = in_pc + imm_b;
      case (opc)
         OPC_OP: begin
            if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
               slot_d.alu_ctr = alu_from_f3(f3, f7[5]);
               slot_d.alu_a   = rf_rdata1;
               slot_d.alu_b   = rf_rdata2;
               slot_d.wb_en   = (rd != 5'd0);
            end else begin
               slot_d.illegal = 1'b1;
            end
         end
         OPC_OPIMM: begin
            // Shifts use imm[11:5] as a funct7; only srai may set bit 30.
            if ((f3 == 3'b001 && f7 != 7'h00) ||
                (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) begin
               slot_d.illegal = 1'b1;
            end else begin
               slot_d.alu_ctr = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
               slot_d.alu_a   = rf_rdata1;
               slot_d.alu_b   = (f3 == 3'b001 || f3 == 3'b101) ?
                                {27'b0, in_inst[24:20]} : imm_i;
               slot_d.wb_en   = (rd != 5'd0);
            end
         end
         OPC_LUI: begin
            slot_d.alu_ctr = ALU_PASB;
            slot_d.alu_b   = imm_u;
            slot_d.wb_en   = (rd != 5'd0);
         end
         OPC_AUIPC: begin
            slot_d.alu_ctr = ALU_ADD;
            slot_d.alu_a   = in_pc;
            slot_d.alu_b   = imm_u;
            slot_d.wb_en   = (rd != 5'd0);
         end
         OPC_BRANCH: begin
            if (f3 == 3'b010 || f3 == 3'b011) begin
               slot_d.illegal = 1'b1;
            end else begin
               slot_d.alu_ctr = (f3[2:1] == 2'b00) ? ALU_SUB :
                                (f3[2:1] == 2'b10) ? ALU_SLT : ALU_SLTU;
               slot_d.alu_a   = rf_rdata1;
               slot_d.alu_b   = rf_rdata2;
               slot_d.br      = f3;
            end
         end
         default: slot_d.illegal = 1'b1;
      endcase
   end

   // flush forces ready so the IFU never stalls on a killed slot.
   assign in_ready = ~valid_q | out_ready | flush;
   assign accept   = in_valid & in_ready & ~flush;

   always_comb begin
      valid_d = valid_q;
      if (flush)          valid_d = 1'b0;
      else if (accept)    valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         slot_q  <= ISSUE_RST;
      end else begin
         valid_q <= valid_d;
         if (accept) slot_q <= slot_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_alu_ctr = slot_q.alu_ctr;
   assign out_alu_a   = slot_q.alu_a;
   assign out_alu_b   = slot_q.alu_b;
   assign out_rd      = slot_q.rd;
   assign out_wb_en   = slot_q.wb_en;
   assign out_br      = slot_q.br;
   assign out_br_tgt  = slot_q.br_tgt;
   assign out_illegal = slot_q.illegal;

endmodule
`default_nettype wire
